// File: rtl/resize_concat_engine_if.sv
// Command, status and SRAM0 bus bundle for resize_concat_engine.
// master = the engine (drives SRAM0 accesses and status), slave = surrounding system.
interface resize_concat_engine_if #(
  parameter int SRAM0_AW = 16
);
  logic                cmd_valid;
  logic [15:0]         cmd_src0_base;
  logic [15:0]         cmd_src1_base;
  logic [15:0]         cmd_dst_base;
  logic [15:0]         cmd_C0;
  logic [15:0]         cmd_C1;
  logic [15:0]         cmd_H;
  logic [15:0]         cmd_W;

  logic                sram_rd_en;
  logic [SRAM0_AW-1:0] sram_rd_addr;
  logic [7:0]          sram_rd_data;
  logic                sram_wr_en;
  logic [SRAM0_AW-1:0] sram_wr_addr;
  logic [7:0]          sram_wr_data;

  logic                busy;
  logic                done;

  modport master (
    input  cmd_valid, cmd_src0_base, cmd_src1_base, cmd_dst_base,
           cmd_C0, cmd_C1, cmd_H, cmd_W, sram_rd_data,
    output sram_rd_en, sram_rd_addr, sram_wr_en, sram_wr_addr, sram_wr_data,
           busy, done
  );

  modport slave (
    output cmd_valid, cmd_src0_base, cmd_src1_base, cmd_dst_base,
           cmd_C0, cmd_C1, cmd_H, cmd_W, sram_rd_data,
    input  sram_rd_en, sram_rd_addr, sram_wr_en, sram_wr_addr, sram_wr_data,
           busy, done
  );
endinterface

// File: rtl/resize_concat_engine.sv
// Channel-concat copy engine: streams tensor A then tensor B from SRAM0 into dst.
// Optional CONCAT_PERF_CNT_EN adds the perf_cycles busy-cycle counter port.
//
// state    | meaning
// CC_IDLE  | waiting for cmd_valid; command latched on acceptance
// CC_COPY  | one read issued per cycle until all elements are issued
// CC_DRAIN | 2 cycles letting the last reads land and write back
// CC_DONE  | done pulse, then back to idle
module resize_concat_engine #(
  parameter int SRAM0_AW = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  resize_concat_engine_if.master bus
`ifdef CONCAT_PERF_CNT_EN
  ,
  output logic [31:0]           perf_cycles
`endif
);

  localparam int AW = SRAM0_AW;

  typedef enum logic [1:0] {
    CC_IDLE,
    CC_COPY,
    CC_DRAIN,
    CC_DONE
  } cc_state_e;

  cc_state_e      state_q, state_d;
  logic [15:0]    src0_q, src0_d;
  logic [15:0]    src1_q, src1_d;
  logic [15:0]    dst_q, dst_d;
  logic [15:0]    n0_q, n0_d;
  logic [15:0]    idx_q, idx_d;
  logic [15:0]    rem_q, rem_d;
  logic           drain_q, drain_d;

  logic           rd_en_q, rd_en_d;
  logic [AW-1:0]  rd_addr_q, rd_addr_d;
  logic [AW-1:0]  wa0_q, wa0_d;
  logic           v1_q, v1_d;
  logic [AW-1:0]  wa1_q, wa1_d;
  logic           wr_en_q, wr_en_d;
  logic [AW-1:0]  wr_addr_q, wr_addr_d;
  logic [7:0]     wr_data_q, wr_data_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic           accept;
  logic [15:0]    n0_w;
  logic [15:0]    total_w;

  assign accept  = (state_q == CC_IDLE) && bus.cmd_valid;
  assign n0_w    = bus.cmd_C0 * bus.cmd_H * bus.cmd_W;
  assign total_w = (bus.cmd_C0 + bus.cmd_C1) * bus.cmd_H * bus.cmd_W;

  always_comb begin
    state_d   = state_q;
    src0_d    = src0_q;
    src1_d    = src1_q;
    dst_d     = dst_q;
    n0_d      = n0_q;
    idx_d     = idx_q;
    rem_d     = rem_q;
    drain_d   = drain_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    wa0_d     = wa0_q;

    unique case (state_q)
      CC_IDLE: begin
        if (accept) begin
          src0_d  = bus.cmd_src0_base;
          src1_d  = bus.cmd_src1_base;
          dst_d   = bus.cmd_dst_base;
          n0_d    = n0_w;
          idx_d   = '0;
          rem_d   = total_w;
          state_d = (total_w == '0) ? CC_DONE : CC_COPY;
        end
      end
      CC_COPY: begin
        // rem_q counts reads still to issue; terminal count hands over to drain
        if (rem_q != '0) begin
          rd_en_d   = 1'b1;
          rd_addr_d = (idx_q < n0_q) ? AW'(src0_q) + AW'(idx_q)
                                     : AW'(src1_q) + AW'(idx_q - n0_q);
          wa0_d     = AW'(dst_q) + AW'(idx_q);
          idx_d     = idx_q + 16'd1;
          rem_d     = rem_q - 16'd1;
        end else begin
          state_d = CC_DRAIN;
          drain_d = 1'b1;
        end
      end
      CC_DRAIN: begin
        if (drain_q == 1'b0) state_d = CC_DONE;
        else                 drain_d = 1'b0;
      end
      CC_DONE: state_d = CC_IDLE;
      default: state_d = CC_IDLE;
    endcase
  end

  // Read-to-write pipeline: address out, data back next cycle, written the cycle after.
  always_comb begin
    v1_d      = rd_en_q;
    wa1_d     = rd_en_q ? wa0_q : wa1_q;
    wr_en_d   = v1_q;
    wr_addr_d = v1_q ? wa1_q : wr_addr_q;
    wr_data_d = v1_q ? bus.sram_rd_data : wr_data_q;
    busy_d    = (state_d != CC_IDLE);
    done_d    = (state_d == CC_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CC_IDLE;
      src0_q    <= '0;
      src1_q    <= '0;
      dst_q     <= '0;
      n0_q      <= '0;
      idx_q     <= '0;
      rem_q     <= '0;
      drain_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wa0_q     <= '0;
      v1_q      <= 1'b0;
      wa1_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      src0_q    <= src0_d;
      src1_q    <= src1_d;
      dst_q     <= dst_d;
      n0_q      <= n0_d;
      idx_q     <= idx_d;
      rem_q     <= rem_d;
      drain_q   <= drain_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      wa0_q     <= wa0_d;
      v1_q      <= v1_d;
      wa1_q     <= wa1_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.sram_rd_en   = rd_en_q;
  assign bus.sram_rd_addr = rd_addr_q;
  assign bus.sram_wr_en   = wr_en_q;
  assign bus.sram_wr_addr = wr_addr_q;
  assign bus.sram_wr_data = wr_data_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

`ifdef CONCAT_PERF_CNT_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (accept)                    perf_d = '0;
    else if (state_q != CC_IDLE)   perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf_q <= '0;
    else        perf_q <= perf_d;
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_resize_concat_engine.sv
// Self-checking bench for resize_concat_engine: directed corner cases plus random
// commands against a spec-level concat model and a behavioural SRAM0.
module tb_resize_concat_engine;

  localparam int AW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  resize_concat_engine_if #(.SRAM0_AW(AW)) sif ();

`ifdef CONCAT_PERF_CNT_EN
  logic [31:0] perf_cycles;
`endif

  resize_concat_engine #(.SRAM0_AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif.master)
`ifdef CONCAT_PERF_CNT_EN
    ,
    .perf_cycles (perf_cycles)
`endif
  );

  // Behavioural SRAM0: synchronous read, write on the clock edge.
  logic [7:0] mem [0:65535];

  always @(posedge clk) begin
    if (sif.sram_rd_en) sif.sram_rd_data <= mem[sif.sram_rd_addr];
  end

  always @(posedge clk) begin
    if (sif.sram_wr_en) mem[sif.sram_wr_addr] = sif.sram_wr_data;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state for the command in flight
  int          m_total, m_n0, done_cyc;
  logic [15:0] m_dst;
  logic [15:0] exp_ra [0:1023];
  logic [7:0]  exp_wd [0:1023];
  logic [15:0] last_ra, last_wa;
  logic [7:0]  last_wd;

  task automatic clear_model();
    last_ra = '0;
    last_wa = '0;
    last_wd = '0;
  endtask

  // Called at a sampling point of an idle cycle; that cycle becomes cycle 0.
  task automatic start_cmd(input int c0, input int c1, input int h, input int w,
                           input logic [15:0] s0, input logic [15:0] s1,
                           input logic [15:0] d);
    m_n0     = (c0 * h * w) & 32'hFFFF;
    m_total  = ((c0 + c1) * h * w) & 32'hFFFF;
    m_dst    = d;
    done_cyc = (m_total == 0) ? 1 : m_total + 4;
    for (int i = 0; i < m_total; i++) begin
      exp_ra[i] = (i < m_n0) ? 16'(s0 + i) : 16'(s1 + (i - m_n0));
      exp_wd[i] = mem[exp_ra[i]];
    end
    sif.cmd_src0_base = s0;
    sif.cmd_src1_base = s1;
    sif.cmd_dst_base  = d;
    sif.cmd_C0        = 16'(c0);
    sif.cmd_C1        = 16'(c1);
    sif.cmd_H         = 16'(h);
    sif.cmd_W         = 16'(w);
    sif.cmd_valid     = 1'b1;
  endtask

  task automatic mon(input int kmax, input bit hold);
    bit e_rd, e_wr;
    for (int k = 1; k <= kmax; k++) begin
      @(posedge clk);
      #1;
      if (!hold || k >= done_cyc) sif.cmd_valid = 1'b0;
      e_rd = (k >= 2) && (k <= m_total + 1);
      e_wr = (k >= 4) && (k <= m_total + 3);
      if (e_rd) last_ra = exp_ra[k-2];
      if (e_wr) begin
        last_wa = 16'(m_dst + (k - 4));
        last_wd = exp_wd[k-4];
      end
      chk("rd_en",   sif.sram_rd_en,   e_rd);
      chk("rd_addr", sif.sram_rd_addr, last_ra);
      chk("wr_en",   sif.sram_wr_en,   e_wr);
      chk("wr_addr", sif.sram_wr_addr, last_wa);
      chk("wr_data", sif.sram_wr_data, last_wd);
      chk("done",    sif.done,         k == done_cyc);
      chk("busy",    sif.busy,         k <= done_cyc);
    end
  endtask

  task automatic run_cmd(input int c0, input int c1, input int h, input int w,
                         input logic [15:0] s0, input logic [15:0] s1,
                         input logic [15:0] d, input bit hold);
    start_cmd(c0, c1, h, w, s0, s1, d);
    mon(done_cyc + 4, hold);
    for (int i = 0; i < m_total; i++)
      chk("dst_mem", mem[16'(m_dst + i)], exp_wd[i]);
`ifdef CONCAT_PERF_CNT_EN
    chk("perf_cycles", perf_cycles, done_cyc);
`endif
  endtask

  logic [7:0] t1_exp [0:7];
  logic [7:0] snap   [0:7];

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    sif.cmd_valid = 1'b0;
    sif.cmd_src0_base = '0; sif.cmd_src1_base = '0; sif.cmd_dst_base = '0;
    sif.cmd_C0 = '0; sif.cmd_C1 = '0; sif.cmd_H = '0; sif.cmd_W = '0;
    clear_model();

    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd_en",   sif.sram_rd_en,   0);
    chk("rst_wr_en",   sif.sram_wr_en,   0);
    chk("rst_rd_addr", sif.sram_rd_addr, 0);
    chk("rst_wr_addr", sif.sram_wr_addr, 0);
    chk("rst_wr_data", sif.sram_wr_data, 0);
    chk("rst_busy",    sif.busy,         0);
    chk("rst_done",    sif.done,         0);
`ifdef CONCAT_PERF_CNT_EN
    chk("rst_perf",    perf_cycles,      0);
`endif
    rst_n = 1'b1;

    // Basic 2x4 concat, accepted in the first cycle after reset release
    for (int i = 0; i < 4; i++) begin
      mem[i]         = 8'(i);
      mem[16'h100+i] = 8'(8'h10 + i);
    end
    t1_exp[0] = 8'h00; t1_exp[1] = 8'h01; t1_exp[2] = 8'h02; t1_exp[3] = 8'h03;
    t1_exp[4] = 8'h10; t1_exp[5] = 8'h11; t1_exp[6] = 8'h12; t1_exp[7] = 8'h13;
    run_cmd(1, 1, 2, 2, 16'h0000, 16'h0100, 16'h0200, 1'b0);
    for (int i = 0; i < 8; i++) chk("t1_dst", mem[16'h200+i], t1_exp[i]);

    // C1=0: src0 only
    run_cmd(2, 0, 1, 3, 16'h0300, 16'h0400, 16'h0500, 1'b0);

    // total=0: done in cycle 1, no SRAM traffic
    run_cmd(0, 0, 5, 5, 16'h1234, 16'h2345, 16'h3456, 1'b0);

    // Read address wraps past 0xFFFF
    run_cmd(4, 0, 1, 1, 16'hFFFE, 16'h2000, 16'h1000, 1'b0);

    // Reset asserted in cycle 5 of an 8-element copy
    for (int i = 0; i < 8; i++) snap[i] = mem[16'h0800+i];
    start_cmd(2, 2, 1, 2, 16'h0600, 16'h0700, 16'h0800);
    mon(4, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rd_en",   sif.sram_rd_en,   0);
    chk("mid_rst_wr_en",   sif.sram_wr_en,   0);
    chk("mid_rst_rd_addr", sif.sram_rd_addr, 0);
    chk("mid_rst_wr_addr", sif.sram_wr_addr, 0);
    chk("mid_rst_wr_data", sif.sram_wr_data, 0);
    chk("mid_rst_busy",    sif.busy,         0);
    chk("mid_rst_done",    sif.done,         0);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("in_rst_wr_en", sif.sram_wr_en, 0);
      chk("in_rst_rd_en", sif.sram_rd_en, 0);
    end
    for (int i = 1; i < 8; i++) chk("rst_no_write", mem[16'h0800+i], snap[i]);
    rst_n = 1'b1;
    clear_model();
    run_cmd(2, 2, 1, 2, 16'h0900, 16'h0A00, 16'h0B00, 1'b0);

    // cmd_valid held through the whole copy: exactly one copy, perf = 12
    run_cmd(4, 4, 1, 1, 16'h0C00, 16'h0D00, 16'h0E00, 1'b1);
`ifdef CONCAT_PERF_CNT_EN
    chk("perf_total8", perf_cycles, 12);
`endif

    // Random commands in disjoint windows
    repeat (24) begin
      int c0, c1, h, w;
      logic [15:0] s0, s1, d;
      c0 = $urandom_range(0, 3);
      c1 = $urandom_range(0, 3);
      h  = $urandom_range(1, 4);
      w  = $urandom_range(1, 4);
      s0 = 16'(32'h4000 + $urandom_range(0, 16'h3F00));
      s1 = 16'(32'h8000 + $urandom_range(0, 16'h3F00));
      d  = 16'(32'hC000 + $urandom_range(0, 16'h3F00));
      run_cmd(c0, c1, h, w, s0, s1, d, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/resize_concat_engine.md
RESIZE_CONCAT_ENGINE -- requirements
Module: resize_concat_engine

Interface
REQ-001 SHALL have parameter SRAM0_AW, default 16, which sets the SRAM0 address width in bits.
REQ-002 SHALL have port clk, input, 1 bit: clock, rising-edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port cmd_valid, input, 1 bit: command strobe.
REQ-005 SHALL have port cmd_src0_base, input, 16 bits: SRAM base of tensor A [1,C0,H,W], typically the upsampled output.
REQ-006 SHALL have port cmd_src1_base, input, 16 bits: SRAM base of tensor B [1,C1,H,W], typically the skip connection.
REQ-007 SHALL have port cmd_dst_base, input, 16 bits: SRAM base of output [1,C0+C1,H,W].
REQ-008 SHALL have ports cmd_C0, cmd_C1, cmd_H and cmd_W, each input, 16 bits: tensor dimensions.
REQ-009 SHALL have ports sram_rd_en (output, 1 bit), sram_rd_addr (output, SRAM0_AW bits) and sram_rd_data (input, 8 bits): SRAM0 synchronous read port.
REQ-010 SHALL have ports sram_wr_en (output, 1 bit), sram_wr_addr (output, SRAM0_AW bits) and sram_wr_data (output, 8 bits): SRAM0 write port.
REQ-011 SHALL have ports busy (output, 1 bit) and done (output, 1 bit): status.
REQ-012 SHALL have port perf_cycles, output, 32 bits, present only under CONCAT_PERF_CNT_EN.

Function
REQ-013 SHALL implement an FSM with states CC_IDLE, CC_COPY, CC_DRAIN and CC_DONE.
REQ-014 SHALL accept a command only in CC_IDLE with cmd_valid=1, latching all cmd_* inputs; cmd_valid in any other state SHALL be ignored.
REQ-015 SHALL compute n0=C0*H*W and total=(C0+C1)*H*W at acceptance, both truncated to 16 bits.
REQ-016 SHALL have total==0 move CC_IDLE->CC_DONE with no SRAM access.
REQ-017 SHALL, in CC_COPY, issue exactly one read per cycle for index i=0..total-1, in order.
REQ-018 SHALL compute the read address as src0_base+i for i<n0, else src1_base+(i-n0), and the write address as dst_base+i; all sums are modulo 2^SRAM0_AW.
REQ-019 SHALL leave CC_COPY for CC_DRAIN after the read for i=total-1 is issued; CC_DRAIN SHALL last exactly 2 cycles, then CC_DONE for 1 cycle, then CC_IDLE.
REQ-020 SHALL meet this timing, with cycle 0 as the acceptance cycle: sram_rd_en high in cycles 2..total+1; sram_rd_data for index i valid in cycle i+3; sram_wr_en high in cycles 4..total+3 with sram_wr_data equal to the data read for i.
REQ-021 SHALL assert done for exactly 1 cycle, cycle total+4 (cycle 1 when total==0); busy SHALL be high whenever the state is not CC_IDLE.
REQ-022 SHALL use registered outputs only; sram_rd_en and sram_wr_en SHALL default low every cycle they are not asserted.
REQ-023 SHALL hold sram_rd_addr, sram_wr_addr and sram_wr_data at their last values while the corresponding enable is low.
REQ-024 SHALL read from issue-time addresses; source/destination overlap is the caller's responsibility and SHALL NOT be detected.

Reset
REQ-025 SHALL, on rst_n=0 at any time including mid-copy, drive state to CC_IDLE and all outputs and registers to 0 immediately, with no further SRAM accesses.
REQ-026 SHALL accept a new command in the first cycle after rst_n deasserts.

Configuration
REQ-027 SHALL, when macro CONCAT_PERF_CNT_EN is defined, provide perf_cycles: cleared to 0 at command acceptance, incremented every cycle busy=1, held after done until the next acceptance, reset to 0.
REQ-028 SHALL, when CONCAT_PERF_CNT_EN is undefined, omit the perf_cycles port and counter, with all other behaviour identical.

Verification
REQ-029 SHALL verify: C0=1,C1=1,H=2,W=2, src0=0x0000 holding 0..3, src1=0x0100 holding 0x10..0x13, dst=0x0200 -> dst 0x0200..0x0207 = 00,01,02,03,10,11,12,13; done in cycle 12.
REQ-030 SHALL verify: C0=2,C1=0,H=1,W=3 -> 6 writes copying src0 only; src1 is never read.
REQ-031 SHALL verify: C0=0,C1=0 -> done in cycle 1, sram_rd_en and sram_wr_en never high.
REQ-032 SHALL verify: SRAM0_AW=16, src0=0xFFFE, total=4 -> reads 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-033 SHALL verify: rst_n pulsed low in cycle 5 of an 8-element copy -> outputs 0 immediately, no writes after reset, and a new command afterwards completes correctly.
REQ-034 SHALL verify: cmd_valid held high during busy -> one copy only; with CONCAT_PERF_CNT_EN and total=8, perf_cycles = 12.
